// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single downstream memory port.
// Round-robin on ties, misalignment rejection, and a bounded wait for m_ack.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              instr_enable,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  output logic [31:0]       instr_result,

  input  logic              data_enable,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic              data_rw,
  input  logic [1:0]        data_oplen,
  input  logic              data_unsigned,
  output logic              data_valid,
  output logic [31:0]       data_result,

  output logic              m_req,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic              m_rw,
  output logic [1:0]        m_oplen,
  output logic              m_unsigned,
  input  logic              m_ack,
  input  logic [31:0]       m_rdata,

  output logic              err_timeout,
  output logic              err_misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        grant_data;
  logic        last_data;
  logic        misalign_q;
  logic [15:0] cnt;

  logic        pick_data;
  logic        data_mis;
  logic        instr_mis;
  logic        sel_mis;
  logic        timed_out;
  logic        capture;
  logic        abort;
  logic [31:0] cap_data;

  always_comb begin
    pick_data = data_enable & (~instr_enable | ~last_data);
    data_mis  = ((data_oplen == 2'd1) & data_addr[0]) |
                ((data_oplen == 2'd2) & (|data_addr[1:0])) |
                (data_oplen == 2'd3);
    instr_mis = |instr_addr[1:0];
    sel_mis   = pick_data ? data_mis : instr_mis;
    // The last counted cycle is TIMEOUT-1, so RESP lands TIMEOUT cycles after ISSUE.
    timed_out = (cnt >= TO_LAST);
    cap_data  = m_rw ? '0 : m_rdata;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_enable | data_enable)
          state_d = sel_mis ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (m_ready & m_ack) begin
          state_d = S_RESP;
          capture = 1'b1;
        end else if (timed_out) begin
          state_d = S_RESP;
          abort   = 1'b1;
        end else if (m_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_ack) begin
          state_d = S_RESP;
          capture = 1'b1;
        end else if (timed_out) begin
          state_d = S_RESP;
          abort   = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_data   <= 1'b0;
      last_data    <= 1'b0;
      misalign_q   <= 1'b0;
      cnt          <= '0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_rw         <= 1'b0;
      m_oplen      <= '0;
      m_unsigned   <= 1'b0;
      instr_result <= '0;
      data_result  <= '0;
      err_timeout  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (instr_enable | data_enable) begin
            grant_data <= pick_data;
            misalign_q <= sel_mis;
            cnt        <= '0;
            if (sel_mis) begin
              if (pick_data) data_result  <= '0;
              else           instr_result <= '0;
            end else if (pick_data) begin
              m_addr     <= data_addr;
              m_wdata    <= data_wdata;
              m_rw       <= data_rw;
              m_oplen    <= data_oplen;
              m_unsigned <= data_unsigned;
            end else begin
              m_addr     <= instr_addr;
              m_wdata    <= '0;
              m_rw       <= 1'b0;
              m_oplen    <= 2'd2;
              m_unsigned <= 1'b0;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          cnt <= cnt + 16'd1;
          if (capture) begin
            if (grant_data) data_result  <= cap_data;
            else            instr_result <= cap_data;
          end else if (abort) begin
            err_timeout <= 1'b1;
            if (grant_data) data_result  <= '0;
            else            instr_result <= '0;
          end
        end
        S_RESP: last_data <= grant_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    m_req        = (state_q == S_ISSUE);
    instr_valid  = (state_q == S_RESP) & ~grant_data;
    data_valid   = (state_q == S_RESP) &  grant_data;
    err_misalign = (state_q == S_RESP) &  misalign_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the downstream memory and
// checks every response against hand-computed values (TIMEOUT overridden to 8).
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 25;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_enable;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;
  logic [31:0]       instr_result;
  logic              data_enable;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_rw;
  logic [1:0]        data_oplen;
  logic              data_unsigned;
  logic              data_valid;
  logic [31:0]       data_result;
  logic              m_req;
  logic              m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic              m_rw;
  logic [1:0]        m_oplen;
  logic              m_unsigned;
  logic              m_ack;
  logic [31:0]       m_rdata;
  logic              err_timeout;
  logic              err_misalign;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .instr_enable(instr_enable), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_result(instr_result),
    .data_enable(data_enable), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rw(data_rw), .data_oplen(data_oplen), .data_unsigned(data_unsigned),
    .data_valid(data_valid), .data_result(data_result),
    .m_req(m_req), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rw(m_rw), .m_oplen(m_oplen), .m_unsigned(m_unsigned),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .err_timeout(err_timeout), .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    instr_enable = 1'b0; instr_addr = '0;
    data_enable = 1'b0; data_addr = '0; data_wdata = '0;
    data_rw = 1'b0; data_oplen = '0; data_unsigned = 1'b0;
    m_ready = 1'b0; m_ack = 1'b0; m_rdata = '0;
    tick; tick;
    chk("rst_mreq",   32'(m_req), 0);
    chk("rst_ivalid", 32'(instr_valid), 0);
    chk("rst_dvalid", 32'(data_valid), 0);
    chk("rst_maddr",  32'(m_addr), 0);
    chk("rst_ires",   instr_result, 0);
    chk("rst_dres",   data_result, 0);
    chk("rst_errto",  32'(err_timeout), 0);
    chk("rst_errmis", 32'(err_misalign), 0);
    rst = 1'b0;

    // Basic fetch: ISSUE next cycle, ack one cycle after acceptance.
    instr_enable = 1'b1; instr_addr = 25'h10; m_ready = 1'b1;
    tick;
    chk("f_mreq",  32'(m_req), 1);
    chk("f_addr",  32'(m_addr), 32'h10);
    chk("f_oplen", 32'(m_oplen), 2);
    chk("f_rw",    32'(m_rw), 0);
    tick;
    chk("f_wait_req", 32'(m_req), 0);
    chk("f_wait_iv",  32'(instr_valid), 0);
    m_ack = 1'b1; m_rdata = 32'h13;
    tick;
    m_ack = 1'b0; m_rdata = '0;
    chk("f_ivalid", 32'(instr_valid), 1);
    chk("f_ires",   instr_result, 32'h13);
    chk("f_dvalid", 32'(data_valid), 0);
    instr_enable = 1'b0;
    tick;
    chk("f_ivalid_off", 32'(instr_valid), 0);
    chk("f_ires_hold",  instr_result, 32'h13);

    // Round-robin with both enables held: data, instr, data.
    instr_enable = 1'b1; instr_addr = 25'h20;
    data_enable = 1'b1; data_addr = 25'h200; data_rw = 1'b0; data_oplen = 2'd2;
    tick;
    chk("rr1_addr", 32'(m_addr), 32'h200);
    tick;
    m_ack = 1'b1; m_rdata = 32'h11111111;
    tick;
    m_ack = 1'b0;
    chk("rr1_dvalid", 32'(data_valid), 1);
    chk("rr1_ivalid", 32'(instr_valid), 0);
    chk("rr1_dres",   data_result, 32'h11111111);
    tick;
    chk("rr_idle_req", 32'(m_req), 0);
    tick;
    chk("rr2_addr",  32'(m_addr), 32'h20);
    chk("rr2_oplen", 32'(m_oplen), 2);
    tick;
    m_ack = 1'b1; m_rdata = 32'h22222222;
    tick;
    m_ack = 1'b0;
    chk("rr2_ivalid", 32'(instr_valid), 1);
    chk("rr2_dvalid", 32'(data_valid), 0);
    chk("rr2_ires",   instr_result, 32'h22222222);
    tick; tick;
    chk("rr3_addr", 32'(m_addr), 32'h200);
    instr_enable = 1'b0;
    tick;
    m_ack = 1'b1; m_rdata = 32'h33333333;
    tick;
    m_ack = 1'b0;
    chk("rr3_dvalid", 32'(data_valid), 1);
    chk("rr3_dres",   data_result, 32'h33333333);
    data_enable = 1'b0;
    tick;

    // Misaligned word store: never issued, straight to RESP.
    data_enable = 1'b1; data_rw = 1'b1; data_oplen = 2'd2;
    data_addr = 25'h102; data_wdata = 32'hdeadbeef;
    tick;
    chk("mis_req",    32'(m_req), 0);
    chk("mis_maddr",  32'(m_addr), 32'h200);
    chk("mis_dvalid", 32'(data_valid), 1);
    chk("mis_dres",   data_result, 0);
    chk("mis_err",    32'(err_misalign), 1);
    data_enable = 1'b0;
    tick;
    chk("mis_err_off",    32'(err_misalign), 0);
    chk("mis_dvalid_off", 32'(data_valid), 0);

    // Aligned halfword store granted to data again; ack together with ready.
    data_enable = 1'b1; data_oplen = 2'd1;
    tick;
    chk("st_req",   32'(m_req), 1);
    chk("st_rw",    32'(m_rw), 1);
    chk("st_oplen", 32'(m_oplen), 1);
    chk("st_wdata", m_wdata, 32'hdeadbeef);
    chk("st_addr",  32'(m_addr), 32'h102);
    m_ack = 1'b1; m_rdata = 32'hffffffff;
    tick;
    m_ack = 1'b0;
    chk("st_dvalid", 32'(data_valid), 1);
    chk("st_dres",   data_result, 0);
    chk("st_err",    32'(err_misalign), 0);
    data_enable = 1'b0;
    tick;

    // Misaligned fetch.
    instr_enable = 1'b1; instr_addr = 25'h12;
    tick;
    chk("imis_req",    32'(m_req), 0);
    chk("imis_ivalid", 32'(instr_valid), 1);
    chk("imis_ires",   instr_result, 0);
    chk("imis_err",    32'(err_misalign), 1);
    instr_enable = 1'b0;
    tick;

    // Byte load stalled 5 cycles; input changes during ISSUE must be ignored.
    data_enable = 1'b1; data_rw = 1'b0; data_oplen = 2'd0; data_unsigned = 1'b1;
    data_addr = 25'h41; m_ready = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",  32'(m_req), 1);
      chk("stall_addr", 32'(m_addr), 32'h41);
      data_addr = 25'h1ff; data_oplen = 2'd2;
      tick;
    end
    chk("stall_oplen", 32'(m_oplen), 0);
    chk("stall_uns",   32'(m_unsigned), 1);
    m_ready = 1'b1;
    tick;
    m_ack = 1'b1; m_rdata = 32'hab;
    tick;
    m_ack = 1'b0;
    chk("stall_dvalid", 32'(data_valid), 1);
    chk("stall_dres",   data_result, 32'hab);
    chk("stall_errto",  32'(err_timeout), 0);
    data_enable = 1'b0;
    tick;

    // Timeout: accepted, never acked; RESP 8 cycles after ISSUE.
    data_enable = 1'b1; data_addr = 25'h300; data_oplen = 2'd2; data_unsigned = 1'b0;
    m_ready = 1'b1;
    tick;
    chk("to_req", 32'(m_req), 1);
    for (int i = 1; i <= 7; i++) begin
      tick;
      chk("to_wait_dvalid", 32'(data_valid), 0);
    end
    chk("to_err_before", 32'(err_timeout), 0);
    tick;
    chk("to_dvalid", 32'(data_valid), 1);
    chk("to_dres",   data_result, 0);
    chk("to_err",    32'(err_timeout), 1);
    chk("to_req_off", 32'(m_req), 0);
    data_enable = 1'b0;
    tick;
    chk("to_sticky",      32'(err_timeout), 1);
    chk("to_dvalid_off",  32'(data_valid), 0);
    tick;
    chk("to_sticky2", 32'(err_timeout), 1);

    // Reset during WAIT aborts; request is then served normally.
    instr_enable = 1'b1; instr_addr = 25'h40;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("rstw_mreq",   32'(m_req), 0);
    chk("rstw_maddr",  32'(m_addr), 0);
    chk("rstw_ires",   instr_result, 0);
    chk("rstw_dres",   data_result, 0);
    chk("rstw_errto",  32'(err_timeout), 0);
    chk("rstw_ivalid", 32'(instr_valid), 0);
    m_ack = 1'b1; m_rdata = 32'h99;
    tick;
    chk("rstw_ivalid2", 32'(instr_valid), 0);
    m_ack = 1'b0;
    rst = 1'b0;
    tick;
    chk("post_req",  32'(m_req), 1);
    chk("post_addr", 32'(m_addr), 32'h40);
    tick;
    m_ack = 1'b1; m_rdata = 32'h55;
    tick;
    m_ack = 1'b0;
    chk("post_ivalid", 32'(instr_valid), 1);
    chk("post_ires",   instr_result, 32'h55);
    instr_enable = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25, width of all memory addresses.
REQ-002 Parameter TIMEOUT, default 1023, max cycles waited for m_ack before abort; range 1..65535.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 instr_enable  in  1  fetch request, level, held until instr_valid.
REQ-006 instr_addr  in  ADDR_W  fetch byte address; always a word (32-bit) read.
REQ-007 instr_valid  out  1  one-cycle fetch completion pulse.
REQ-008 instr_result  out  32  fetched word, valid while instr_valid=1.
REQ-009 data_enable  in  1  load/store request, level, held until data_valid.
REQ-010 data_addr, data_wdata, data_rw, data_oplen, data_unsigned  in  ADDR_W/32/1/2/1  address, store data, 1=write, oplen 0=byte 1=half 2=word, zero-extend loads.
REQ-011 data_valid  out  1  one-cycle data completion pulse; data_result  out  32  load result (0 for stores).
REQ-012 m_req  out  1  downstream request; m_ready  in  1  downstream accepts request when m_req=m_ready=1.
REQ-013 m_addr, m_wdata, m_rw, m_oplen, m_unsigned  out  ADDR_W/32/1/2/1  downstream command fields.
REQ-014 m_ack  in  1  downstream completion pulse; m_rdata  in  32  read data valid with m_ack.
REQ-015 err_timeout  out  1  sticky timeout flag; err_misalign  out  1  one-cycle misaligned-access pulse.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-017 IDLE: if any enable high, select grantee, register its command into m_* fields, go ISSUE next cycle.
REQ-018 Both enables high in IDLE: grant requester not granted last (round-robin); after reset last-grant = instr, so data wins first tie.
REQ-019 Single enable high: that requester granted regardless of last-grant.
REQ-020 Instr grant drives m_rw=0, m_oplen=2, m_unsigned=0, m_wdata=0.
REQ-021 ISSUE: m_req=1, command fields stable; on m_ready=1 go WAIT; m_req=0 in all other states.
REQ-022 WAIT: on m_ack=1 capture m_rdata (0 if write) into grantee's result register, go RESP.
REQ-023 m_ack in the same cycle as m_ready acceptance is legal: go directly to RESP with captured data.
REQ-024 RESP: grantee's valid=1 for exactly one cycle, other valid=0; update last-grant; return IDLE.
REQ-025 Request sampling resumes in IDLE the cycle after RESP; minimum turnaround 4 cycles (IDLE, ISSUE, WAIT, RESP) with m_ready=1 and m_ack one cycle after acceptance.
REQ-026 Misalignment: data oplen=1 with addr[0]=1, or oplen=2 with addr[1:0]!=0, or oplen=3; detected in IDLE, not issued downstream, go RESP with data_result=0 and err_misalign=1 during RESP.
REQ-027 Instr fetch with instr_addr[1:0]!=0 is misaligned likewise (instr_result=0, err_misalign pulse).
REQ-028 Timeout counter (16 bit) clears entering ISSUE, increments each cycle in ISSUE/WAIT; reaching TIMEOUT goes RESP with result 0, sets err_timeout, m_req drops.
REQ-029 err_timeout remains 1 until rst.
REQ-030 Enable dropped by requester while granted: transaction completes downstream; valid pulse still issued.
REQ-031 Inputs sampled only in IDLE; changes to address/data during ISSUE/WAIT have no effect.
REQ-032 instr_result and data_result hold last value outside RESP.

Reset
REQ-033 On rst: state IDLE, m_req=0, m_* command fields 0, instr_valid=data_valid=0, results 0, err_timeout=0, err_misalign=0, counter 0, last-grant=instr.
REQ-034 rst asserted mid-transaction aborts immediately, no valid pulse; downstream must be reset by same rst.
REQ-035 First request considered on first posedge after rst deasserts.

Verification
REQ-036 instr_enable=1, addr=0x10, m_ready=1, m_ack one cycle later with m_rdata=0x00000013 -> m_req at cycle 1, instr_valid at cycle 3 with instr_result=0x00000013.
REQ-037 Both enables high after reset, held -> data granted first, then instr; next tie after that granted data again.
REQ-038 data store, oplen=2, addr=0x102 -> no m_req, data_valid one cycle with result 0, err_misalign pulse.
REQ-039 TIMEOUT=8, m_ready=1, m_ack never -> data_valid 8 cycles after acceptance window start, result 0, err_timeout=1 and stays 1.
REQ-040 m_ready=0 for 5 cycles in ISSUE -> m_req and fields held stable 5 cycles; completion after m_ack with correct data.
REQ-041 rst pulsed during WAIT -> all outputs to reset values, no valid pulse, new request served normally after release.
